// File: rtl/rps_input_conditioner.sv
// rps_input_conditioner
// Front end of the rock-paper-scissors game. The three on-board buttons
// (active-high) and the three PMOD inputs (active-low) are synchronised,
// merged into rock/paper/scissors channels and debounced. A single choice
// per press is offered downstream over a valid/ready handshake. The block
// then waits until every channel is released before it arms again.

module rps_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int CNT_W           = 17
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       BTN1,
    input  logic       BTN2,
    input  logic       BTN3,
    input  logic       P1A1,
    input  logic       P1A2,
    input  logic       P1A3,
    output logic [1:0] CHOICE,
    output logic       CHOICE_VALID,
    input  logic       CHOICE_READY,
    output logic       HELD
);

    // Terminal count of the debounce counter. The level toggles on the
    // cycle the counter reaches this value while still disagreeing.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Handshake FSM encoding
    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_OFFER        = 2'd1;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd2;

    // Choice codes, bit index 0 = rock, 1 = paper, 2 = scissors
    localparam logic [1:0] CH_NONE     = 2'd0;
    localparam logic [1:0] CH_ROCK     = 2'd1;
    localparam logic [1:0] CH_PAPER    = 2'd2;
    localparam logic [1:0] CH_SCISSORS = 2'd3;

    // Two-stage synchronisers, one bit per raw input
    logic [2:0] btn_sync1_q, btn_sync1_d;
    logic [2:0] btn_sync2_q, btn_sync2_d;
    logic [2:0] p1a_sync1_q, p1a_sync1_d;
    logic [2:0] p1a_sync2_q, p1a_sync2_d;

    // Merged active-high channel levels after synchronisation
    logic [2:0] merged;

    // Debounce counters and accepted levels per channel
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]       deb_q, deb_d;

    // Handshake state and registered outputs
    logic [1:0] state_q, state_d;
    logic [1:0] choice_q, choice_d;
    logic       valid_q, valid_d;
    logic       held_q, held_d;

    // Next values of the synchroniser chains: shift the raw pins in
    always_comb begin
        btn_sync1_d = {BTN3, BTN2, BTN1};
        btn_sync2_d = btn_sync1_q;
        p1a_sync1_d = {P1A3, P1A2, P1A1};
        p1a_sync2_d = p1a_sync1_q;
    end

    // Buttons are active-high, PMOD lines are active-low; either one selects the channel
    assign merged = btn_sync2_q | ~p1a_sync2_q;

    // Debounce: a channel level is accepted only after it disagrees with
    // the current state for DEBOUNCE_CYCLES consecutive cycles
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (merged[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                deb_d[i] = ~deb_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Handshake FSM: latch one prioritised choice, offer it, then wait for all releases
    always_comb begin
        state_d  = state_q;
        choice_d = choice_q;
        valid_d  = valid_q;
        held_d   = |deb_q;
        case (state_q)
            ST_IDLE: begin
                if (|deb_q) begin
                    state_d = ST_OFFER;
                    valid_d = 1'b1;
                    if (deb_q[0]) begin
                        choice_d = CH_ROCK;
                    end else if (deb_q[1]) begin
                        choice_d = CH_PAPER;
                    end else begin
                        choice_d = CH_SCISSORS;
                    end
                end
            end
            ST_OFFER: begin
                if (CHOICE_READY) begin
                    state_d  = ST_WAIT_RELEASE;
                    valid_d  = 1'b0;
                    choice_d = CH_NONE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (deb_q == 3'b000) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                valid_d  = 1'b0;
                choice_d = CH_NONE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            btn_sync1_q <= 3'b000;
            btn_sync2_q <= 3'b000;
            p1a_sync1_q <= 3'b111;
            p1a_sync2_q <= 3'b111;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
            deb_q    <= 3'b000;
            state_q  <= ST_IDLE;
            choice_q <= CH_NONE;
            valid_q  <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            btn_sync1_q <= btn_sync1_d;
            btn_sync2_q <= btn_sync2_d;
            p1a_sync1_q <= p1a_sync1_d;
            p1a_sync2_q <= p1a_sync2_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            deb_q    <= deb_d;
            state_q  <= state_d;
            choice_q <= choice_d;
            valid_q  <= valid_d;
            held_q   <= held_d;
        end
    end

    assign CHOICE       = choice_q;
    assign CHOICE_VALID = valid_q;
    assign HELD         = held_q;

endmodule

// File: tb/tb_rps_input_conditioner.sv
// tb_rps_input_conditioner
// Drives directed game scenarios followed by random presses, bounces,
// backpressure and resets. A behavioural model tracks what the outputs
// must be, and every cycle the DUT is compared against it.

module tb_rps_input_conditioner;

    localparam int D     = 8;
    localparam int CNT_W = 17;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic       BTN1 = 1'b0, BTN2 = 1'b0, BTN3 = 1'b0;
    logic       P1A1 = 1'b1, P1A2 = 1'b1, P1A3 = 1'b1;
    logic       CHOICE_READY = 1'b1;
    logic [1:0] CHOICE;
    logic       CHOICE_VALID;
    logic       HELD;

    int checks = 0;
    int passed = 0;
    int edge_cnt = 0;
    bit cmp_en = 1'b0;

    // Model state: merged levels delayed by the two synchroniser stages,
    // a window of recent merged samples per channel, and the game flow
    bit [2:0]   m_d1, m_d2;
    bit [2:0]   m_deb;
    bit [D-1:0] m_win [3];
    int         m_fill [3];
    bit         m_pending, m_armed, m_held;
    int         m_val;
    bit         m_any;

    // Observation logs used by the directed checks
    int xfers[$];
    int valid_cycles = 0;
    int rise_edge = -1, held_rise = -1, held_fall = -1;
    bit prev_valid = 1'b0, prev_held = 1'b0;

    // Random stimulus bookkeeping
    int hold_left [6];
    bit lvl [6];

    always #5 CLK = ~CLK;

    rps_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK),
        .RESETN(RESETN),
        .BTN1(BTN1),
        .BTN2(BTN2),
        .BTN3(BTN3),
        .P1A1(P1A1),
        .P1A2(P1A2),
        .P1A3(P1A3),
        .CHOICE(CHOICE),
        .CHOICE_VALID(CHOICE_VALID),
        .CHOICE_READY(CHOICE_READY),
        .HELD(HELD)
    );

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Behavioural model, advanced on every clock edge from pre-edge values
    always @(posedge CLK) begin
        edge_cnt++;
        if (CHOICE_VALID && CHOICE_READY) begin
            xfers.push_back(int'(CHOICE));
        end
        if (!RESETN) begin
            m_d1 = 3'b000;
            m_d2 = 3'b000;
            m_deb = 3'b000;
            for (int c = 0; c < 3; c++) begin
                m_win[c] = '0;
                m_fill[c] = 0;
            end
            m_pending = 1'b0;
            m_armed = 1'b1;
            m_held = 1'b0;
            m_val = 0;
        end else begin
            m_any = |m_deb;
            if (m_pending) begin
                if (CHOICE_READY) m_pending = 1'b0;
            end else if (m_armed) begin
                if (m_any) begin
                    m_pending = 1'b1;
                    m_armed = 1'b0;
                    m_val = m_deb[0] ? 1 : (m_deb[1] ? 2 : 3);
                end
            end else if (!m_any) begin
                m_armed = 1'b1;
            end
            m_held = m_any;
            // A level is accepted once the last D merged samples all disagree with it
            for (int c = 0; c < 3; c++) begin
                m_win[c] = {m_win[c][D-2:0], m_d2[c]};
                if (m_fill[c] < D) m_fill[c]++;
                if (m_fill[c] == D && m_win[c] == (m_deb[c] ? {D{1'b0}} : {D{1'b1}})) begin
                    m_deb[c] = ~m_deb[c];
                    m_fill[c] = 0;
                end
            end
            m_d2 = m_d1;
            m_d1 = {BTN3 | ~P1A3, BTN2 | ~P1A2, BTN1 | ~P1A1};
        end
    end

    // Per-cycle compare against the model plus edge logging for directed checks
    always @(negedge CLK) begin
        if (cmp_en) begin
            check_output("valid", int'(CHOICE_VALID), int'(m_pending));
            check_output("choice", int'(CHOICE), m_pending ? m_val : 0);
            check_output("held", int'(HELD), int'(m_held));
        end
        if (CHOICE_VALID) valid_cycles++;
        if (rise_edge < 0 && CHOICE_VALID && !prev_valid) rise_edge = edge_cnt;
        if (held_rise < 0 && HELD && !prev_held) held_rise = edge_cnt;
        if (held_fall < 0 && !HELD && prev_held) held_fall = edge_cnt;
        prev_valid = CHOICE_VALID;
        prev_held = HELD;
    end

    task automatic clear_logs();
        xfers.delete();
        valid_cycles = 0;
        rise_edge = -1;
        held_rise = -1;
        held_fall = -1;
    endtask

    task automatic apply_stimulus();
        int pe, re, le, rr;

        // Reset state
        wait_cycles(3);
        check_output("reset_valid", int'(CHOICE_VALID), 0);
        check_output("reset_choice", int'(CHOICE), 0);
        check_output("reset_held", int'(HELD), 0);
        cmp_en = 1'b1;
        RESETN = 1'b1;
        wait_cycles(5);

        // Clean press on BTN2
        clear_logs();
        BTN2 = 1'b1;
        pe = edge_cnt + 1;
        wait_cycles(20);
        BTN2 = 1'b0;
        re = edge_cnt + 1;
        held_fall = -1;
        wait_cycles(30);
        check_output("clean_xfers", xfers.size(), 1);
        if (xfers.size() > 0) check_output("clean_choice", xfers[0], 2);
        check_output("clean_valid_lat", rise_edge - pe, 10);
        check_output("clean_valid_width", valid_cycles, 1);
        check_output("clean_held_rise", held_rise - pe, 10);
        check_output("clean_held_fall", held_fall - re, 10);

        // Bouncing PMOD rock line
        clear_logs();
        for (int s = 0; s < 10; s++) begin
            P1A1 = (s % 2 == 0) ? 1'b0 : 1'b1;
            wait_cycles(3);
        end
        check_output("bounce_quiet", valid_cycles, 0);
        P1A1 = 1'b0;
        le = edge_cnt + 1;
        wait_cycles(20);
        check_output("bounce_xfers", xfers.size(), 1);
        if (xfers.size() > 0) check_output("bounce_choice", xfers[0], 1);
        check_output("bounce_lat", rise_edge - le, 10);
        P1A1 = 1'b1;
        wait_cycles(30);

        // Simultaneous press, then a new press while still held
        clear_logs();
        BTN1 = 1'b1;
        BTN3 = 1'b1;
        wait_cycles(15);
        BTN2 = 1'b1;
        wait_cycles(15);
        BTN1 = 1'b0;
        BTN3 = 1'b0;
        wait_cycles(15);
        BTN2 = 1'b0;
        wait_cycles(30);
        check_output("simul_xfers", xfers.size(), 1);
        if (xfers.size() > 0) check_output("simul_choice", xfers[0], 1);

        // Backpressure on a scissors offer
        clear_logs();
        CHOICE_READY = 1'b0;
        BTN3 = 1'b1;
        wait_cycles(15);
        BTN3 = 1'b0;
        wait_cycles(40);
        check_output("bp_valid_held", int'(CHOICE_VALID), 1);
        check_output("bp_choice_held", int'(CHOICE), 3);
        check_output("bp_no_xfer", xfers.size(), 0);
        CHOICE_READY = 1'b1;
        wait_cycles(1);
        check_output("bp_xfers", xfers.size(), 1);
        if (xfers.size() > 0) check_output("bp_xfer_choice", xfers[0], 3);
        check_output("bp_valid_drop", int'(CHOICE_VALID), 0);
        wait_cycles(10);

        // Reset in the middle of an offer with the button still held
        clear_logs();
        CHOICE_READY = 1'b0;
        BTN1 = 1'b1;
        wait_cycles(15);
        check_output("rst_offer_up", int'(CHOICE_VALID), 1);
        RESETN = 1'b0;
        wait_cycles(1);
        check_output("rst_valid", int'(CHOICE_VALID), 0);
        check_output("rst_choice", int'(CHOICE), 0);
        check_output("rst_held", int'(HELD), 0);
        RESETN = 1'b1;
        rr = edge_cnt + 1;
        rise_edge = -1;
        wait_cycles(15);
        check_output("rst_reissue_lat", rise_edge - rr, 10);
        check_output("rst_reissue_choice", int'(CHOICE), 1);
        CHOICE_READY = 1'b1;
        wait_cycles(2);
        BTN1 = 1'b0;
        wait_cycles(20);

        // Repeated play: rock, paper, scissors
        clear_logs();
        BTN1 = 1'b1; wait_cycles(20); BTN1 = 1'b0; wait_cycles(20);
        BTN2 = 1'b1; wait_cycles(20); BTN2 = 1'b0; wait_cycles(20);
        BTN3 = 1'b1; wait_cycles(20); BTN3 = 1'b0; wait_cycles(20);
        check_output("play_xfers", xfers.size(), 3);
        if (xfers.size() == 3) begin
            check_output("play_first", xfers[0], 1);
            check_output("play_second", xfers[1], 2);
            check_output("play_third", xfers[2], 3);
        end

        // Random presses, bounces, backpressure and occasional resets
        for (int k = 0; k < 6; k++) begin
            hold_left[k] = $urandom_range(1, 60);
            lvl[k] = 1'b0;
        end
        for (int n = 0; n < 4000; n++) begin
            @(negedge CLK);
            for (int k = 0; k < 6; k++) begin
                if (hold_left[k] == 0) begin
                    lvl[k] = ~lvl[k];
                    if (lvl[k]) begin
                        hold_left[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(9, 35);
                    end else begin
                        hold_left[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(20, 150);
                    end
                end
                hold_left[k]--;
            end
            BTN1 = lvl[0];
            BTN2 = lvl[1];
            BTN3 = lvl[2];
            P1A1 = ~lvl[3];
            P1A2 = ~lvl[4];
            P1A3 = ~lvl[5];
            if ($urandom_range(0, 7) == 0) CHOICE_READY = ~CHOICE_READY;
            RESETN = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
        end
        RESETN = 1'b1;
        wait_cycles(5);
    endtask

    initial begin
        apply_stimulus();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/rps_input_conditioner.md
# rps_input_conditioner

Front-end stage for the rock-paper-scissors game on the iCEBreaker. It synchronises and debounces the three on-board buttons and the three active-low PMOD inputs, and merges them into three choice channels. It issues exactly one ROCK/PAPER/SCISSORS choice per press over a valid/ready handshake to the game logic downstream. It re-arms only after every input has been released.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 120000: consecutive cycles a synchronised level must hold before it is accepted (10 ms at 12 MHz). Legal range is 2 to 2^CNT_W−1.
- CNT_W, default 17: debounce counter width.

Ports:
- CLK  in  1  system clock; the block's only clock.
- RESETN  in  1  synchronous, active-low reset.
- BTN1, BTN2, BTN3  in  1 each  on-board buttons, active-high, asynchronous.
- P1A1, P1A2, P1A3  in  1 each  PMOD inputs, active-low, asynchronous.
- CHOICE  out  2  1 = ROCK, 2 = PAPER, 3 = SCISSORS. Reads 0 whenever CHOICE_VALID is low.
- CHOICE_VALID  out  1  a choice is offered; held until accepted.
- CHOICE_READY  in  1  downstream accepts; a transfer occurs on a cycle where VALID and READY are both high.
- HELD  out  1  at least one debounced channel is active.

## Operation
- **Synchronisers.** Each of the 6 raw inputs passes through a 2-flop synchroniser.
  - Reset values: BTN flops 0, P1A flops 1.
- **Channel merge** (after synchronisation):
  - rock = BTN1 | ~P1A1
  - paper = BTN2 | ~P1A2
  - scissors = BTN3 | ~P1A3
- **Debounce, per channel.** Each channel has a CNT_W-bit counter and a debounced state bit.
  - Merged level equals the debounced state: counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES−1 while still differing, the state toggles and the counter clears.
  - A pulse shorter than DEBOUNCE_CYCLES is ignored; the counter restarts on every bounce.
- **HELD** = OR of the three debounced states, registered.
- **FSM**, states IDLE, OFFER, WAIT_RELEASE. Reset state is IDLE.
  - IDLE: on any debounced state high, latch CHOICE by fixed priority rock > paper > scissors, then go to OFFER.
  - OFFER: CHOICE_VALID = 1 and CHOICE is held stable. Changes on the inputs are ignored. When CHOICE_READY = 1, go to WAIT_RELEASE.
  - WAIT_RELEASE: CHOICE = 0 and CHOICE_VALID = 0. When all three debounced states are 0, go to IDLE.
- **Boundary cases:**
  - Simultaneous presses are resolved by priority only; no second choice is issued for the other buttons.
  - A release during OFFER does not cancel the offer. The handshake completes, then WAIT_RELEASE exits on the next cycle.
  - A new press during WAIT_RELEASE, while another channel is still held, is never issued.
  - READY may be high before VALID rises. The transfer then happens in the first VALID cycle.
  - Reset mid-operation: on the first edge with RESETN = 0, the FSM, counters and debounced states clear, and all outputs go to reset values. A button held through reset is re-debounced and issued as a fresh choice.
- **Reset value of every output:** CHOICE = 0, CHOICE_VALID = 0, HELD = 0.

## Timing
- **Press latency.** Let t be the first cycle the raw input is stable active.
  - Merged level is high at t+2.
  - Debounced state rises at t+2+DEBOUNCE_CYCLES.
  - CHOICE_VALID and HELD rise at t+3+DEBOUNCE_CYCLES.
- **Handshake.**
  - CHOICE_VALID falls on the edge after the accepting cycle.
  - Minimum VALID width is 1 cycle, when READY is already high.
- **Release latency.**
  - The debounced state falls DEBOUNCE_CYCLES+2 cycles after the raw release.
  - WAIT_RELEASE → IDLE follows 1 cycle later, and HELD falls at the same edge.
- **Earliest next choice** after re-arm: DEBOUNCE_CYCLES+3 cycles after the next raw press.
- All outputs are registered, with no combinational path from input to output.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 8, with CHOICE_READY tied high unless stated.
1. **Clean press.** BTN2 pulsed high for 20 cycles, starting at t → CHOICE_VALID high for exactly 1 cycle at t+11 with CHOICE = 2. HELD is high from t+11 until 11 cycles after release. One pulse total.
2. **Bounce.** P1A1 toggles low/high every 3 cycles for 30 cycles, then stays low → no CHOICE_VALID during bouncing. Exactly one CHOICE = 1 arrives 11 cycles after the last edge.
3. **Simultaneous, and press during WAIT_RELEASE.**
   - BTN1 and BTN3 rise on the same cycle → a single choice, CHOICE = 1.
   - BTN2 pressed while BTN1 still held, then all released → no further choice.
4. **Backpressure.** CHOICE_READY = 0, BTN3 pressed for 15 cycles then released → CHOICE_VALID = 1 with CHOICE = 3 is held stable. Raising READY 40 cycles later completes a one-cycle transfer, and VALID drops the next cycle.
5. **Reset mid-offer.**
   - RESETN = 0 for 1 cycle while in OFFER → next cycle CHOICE = 0, VALID = 0, HELD = 0.
   - With BTN1 still held, CHOICE = 1 re-issues 11 cycles after RESETN returns high.
6. **Repeated play.** Sequence rock, paper, scissors, with each press 20 cycles and 20-cycle gaps → exactly three transfers, with CHOICE values 1, 2, 3 in order.
